alu_bist_sequencer: RTL and testbench
=====================================

ALU_BIST_SEQUENCER -- requirements
Module: alu_bist_sequencer

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 16: width of the ALU result and of the expected value.
REQ-002 SHALL have parameter REG_ADDR_BITS, default 3: width of each register address.
REQ-003 SHALL have parameter VEC_ADDR_BITS, default 5: width of the vector ROM address.
REQ-004 SHALL have parameter NUM_VECTORS, default 8: vectors per run, legal range 1..2^VEC_ADDR_BITS.
REQ-005 SHALL have parameter SETTLE_CYCLES, default 2: clocks from operand issue to result sample, legal range 1..15.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port start, input, 1 bit: one-cycle pulse that begins a run.
REQ-009 SHALL have port vec_addr, output, VEC_ADDR_BITS bits: vector ROM address.
REQ-010 SHALL have port vec_data, input, 4+2*REG_ADDR_BITS+REG_WIDTH bits: ROM word {opcode[4], regA, regB, expected}, MSB first; synchronous ROM with 1-cycle read latency.
REQ-011 SHALL have port aluResult, input, REG_WIDTH bits: result from the CPU datapath.
REQ-012 SHALL have ports aluOpCode (4 bits), regAddressA and regAddressB (REG_ADDR_BITS each), outputs: operands driven to the CPU.
REQ-013 SHALL have port regWriteEnable, output, 1 bit: CPU register write strobe.
REQ-014 SHALL have ports busy, done, pass, outputs, 1 bit each: run status.
REQ-015 SHALL have port fail_count, output, 8 bits: number of mismatching vectors.
REQ-016 SHALL have port first_fail_index, output, VEC_ADDR_BITS bits: index of the first mismatching vector.

Function
REQ-017 SHALL implement states IDLE, FETCH, LOAD, ISSUE, SETTLE, CHECK, DONE.
REQ-018 SHALL, in IDLE or DONE, on start=1: clear the index, fail_count, first_fail_index and done; enter FETCH.
REQ-019 SHALL, in FETCH, drive vec_addr=index and enter LOAD the next cycle, giving 1 cycle of ROM latency.
REQ-020 SHALL, in LOAD, register vec_data fields and enter ISSUE.
REQ-021 SHALL, in ISSUE, drive aluOpCode, regAddressA and regAddressB from the registered vector, pulse regWriteEnable for exactly 1 cycle, load the settle counter with SETTLE_CYCLES-1, and enter SETTLE.
REQ-022 SHALL hold aluOpCode, regAddressA and regAddressB stable from ISSUE through CHECK.
REQ-023 SHALL decrement the settle counter in SETTLE and enter CHECK when it reads 0.
REQ-024 SHALL, in CHECK on aluResult != expected: increment fail_count, saturating at 255, and latch first_fail_index only on the first mismatch.
REQ-025 SHALL, from CHECK, enter DONE if index==NUM_VECTORS-1; otherwise increment index and enter FETCH.
REQ-026 SHALL produce a per-vector latency of exactly 4+SETTLE_CYCLES clocks from FETCH to the next FETCH.
REQ-027 SHALL keep busy=1 in every state except IDLE and DONE.
REQ-028 SHALL, in DONE, hold done=1 and pass=(fail_count==0) until the next start or reset.
REQ-029 SHALL ignore start while busy=1.
REQ-030 SHALL never let the index exceed NUM_VECTORS-1 and SHALL never drive vec_addr beyond it.

Reset
REQ-031 SHALL, on reset=1 in any state including mid-run, asynchronously enter IDLE.
REQ-032 SHALL, on reset, set all outputs to 0: aluOpCode, addresses, vec_addr, regWriteEnable, busy, done, pass, fail_count and first_fail_index.
REQ-033 SHALL begin normal operation on the first rising clk after reset deasserts.

Configuration
REQ-034 SHALL, when macro ALU_BIST_STOP_ON_FAIL_EN is defined, go from CHECK directly to DONE on the first mismatch; fail_count is then 1 and pass is 0.
REQ-035 SHALL, when ALU_BIST_STOP_ON_FAIL_EN is undefined, run all NUM_VECTORS vectors regardless of mismatches.

Verification
REQ-036 SHALL cover: CPU regs r0..r3 = 0,1,2,3; ROM {ADD 0101,r1,r1,exp 2}, NUM_VECTORS=1 -> after start, done=1, pass=1 and fail_count=0 at clock 7.
REQ-037 SHALL cover: 8 vectors {AND r3,r3=3; OR r2,r2=2; XOR r3,r3=0; SUB r1,r0=1; ...}, all correct -> done, pass=1, busy high for 8*6 clocks.
REQ-038 SHALL cover: vector 2 expects 5 but the ALU gives 0; without the macro -> fail_count=1, first_fail_index=2, pass=0, all 8 vectors run; with the macro -> DONE after vector 2.
REQ-039 SHALL cover: all 8 vectors mismatch -> fail_count=8 and first_fail_index=0.
REQ-040 SHALL cover: reset asserted during SETTLE of vector 3 -> all outputs 0 immediately (asynchronous); a new start reruns from index 0.
REQ-041 SHALL cover: start pulsed while busy -> ignored; start pulsed in DONE -> counters clear and a new run begins.

Source files
------------

// File: rtl/alu_bist_sequencer.sv
// Built-in self-test sequencer: replays ROM vectors through the CPU ALU and tallies mismatches.
// Optional macro ALU_BIST_STOP_ON_FAIL_EN ends the run at the first mismatching vector.
module alu_bist_sequencer #(
    parameter int REG_WIDTH     = 16,
    parameter int REG_ADDR_BITS = 3,
    parameter int VEC_ADDR_BITS = 5,
    parameter int NUM_VECTORS   = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      start,
    output logic [VEC_ADDR_BITS-1:0]                  vec_addr,
    input  logic [4+2*REG_ADDR_BITS+REG_WIDTH-1:0]    vec_data,
    input  logic [REG_WIDTH-1:0]                      aluResult,
    output logic [3:0]                                aluOpCode,
    output logic [REG_ADDR_BITS-1:0]                  regAddressA,
    output logic [REG_ADDR_BITS-1:0]                  regAddressB,
    output logic                                      regWriteEnable,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      pass,
    output logic [7:0]                                fail_count,
    output logic [VEC_ADDR_BITS-1:0]                  first_fail_index
);

    localparam int VEC_WIDTH = 4 + 2 * REG_ADDR_BITS + REG_WIDTH;
    localparam logic [VEC_ADDR_BITS-1:0] LAST_INDEX  = VEC_ADDR_BITS'(NUM_VECTORS - 1);
    localparam logic [3:0]               SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_ISSUE  = 3'd3;
    localparam logic [2:0] S_SETTLE = 3'd4;
    localparam logic [2:0] S_CHECK  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    logic [2:0]               stateR;
    logic [VEC_ADDR_BITS-1:0] indexR;
    logic [3:0]               settleCntR;
    logic [REG_WIDTH-1:0]     expectedR;
    logic                     mismatchS;
    logic                     lastVecS;
    logic                     endRunS;

    function automatic logic [7:0] satInc8(input logic [7:0] value);
        if (value == 8'hFF) begin
            return value;
        end else begin
            return value + 8'd1;
        end
    endfunction

    // Per-vector verdict and end-of-run decision, evaluated during CHECK
    always_comb begin
        mismatchS = (aluResult != expectedR);
        lastVecS  = (indexR == LAST_INDEX);
`ifdef ALU_BIST_STOP_ON_FAIL_EN
        endRunS   = lastVecS | mismatchS;
`else
        endRunS   = lastVecS;
`endif
    end

    // Sequencer state, operand registers and run status
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateR           <= S_IDLE;
            indexR           <= '0;
            settleCntR       <= 4'd0;
            expectedR        <= '0;
            vec_addr         <= '0;
            aluOpCode        <= 4'd0;
            regAddressA      <= '0;
            regAddressB      <= '0;
            regWriteEnable   <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            fail_count       <= 8'd0;
            first_fail_index <= '0;
        end else begin
            case (stateR)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        stateR           <= S_FETCH;
                        indexR           <= '0;
                        vec_addr         <= '0;
                        fail_count       <= 8'd0;
                        first_fail_index <= '0;
                        done             <= 1'b0;
                        pass             <= 1'b0;
                        busy             <= 1'b1;
                    end
                end
                S_FETCH: begin
                    stateR <= S_LOAD;
                end
                S_LOAD: begin
                    // Operand outputs are loaded here so they are already valid throughout ISSUE
                    aluOpCode      <= vec_data[VEC_WIDTH-1 -: 4];
                    regAddressA    <= vec_data[VEC_WIDTH-5 -: REG_ADDR_BITS];
                    regAddressB    <= vec_data[VEC_WIDTH-5-REG_ADDR_BITS -: REG_ADDR_BITS];
                    expectedR      <= vec_data[REG_WIDTH-1:0];
                    regWriteEnable <= 1'b1;
                    stateR         <= S_ISSUE;
                end
                S_ISSUE: begin
                    regWriteEnable <= 1'b0;
                    settleCntR     <= SETTLE_LOAD;
                    stateR         <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (settleCntR == 4'd0) begin
                        stateR <= S_CHECK;
                    end else begin
                        settleCntR <= settleCntR - 4'd1;
                    end
                end
                S_CHECK: begin
                    if (mismatchS) begin
                        fail_count <= satInc8(fail_count);
                        if (fail_count == 8'd0) begin
                            first_fail_index <= indexR;
                        end
                    end
                    if (endRunS) begin
                        stateR <= S_DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        pass   <= (fail_count == 8'd0) && !mismatchS;
                    end else begin
                        indexR   <= indexR + VEC_ADDR_BITS'(1);
                        vec_addr <= indexR + VEC_ADDR_BITS'(1);
                        stateR   <= S_FETCH;
                    end
                end
                default: begin
                    stateR         <= S_IDLE;
                    busy           <= 1'b0;
                    regWriteEnable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_bist_sequencer.sv
// Bench for alu_bist_sequencer: a run-level model checked every cycle plus directed literal checks.
module tb_alu_bist_sequencer;

    localparam int RW  = 16;
    localparam int RA  = 3;
    localparam int VA  = 5;
    localparam int NV  = 8;
    localparam int SC  = 2;
    localparam int PER = 4 + SC;
`ifdef ALU_BIST_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start8 = 1'b0;
    logic start1 = 1'b0;

    logic [VA-1:0]          vecAddr8, first8, vecAddr1, first1;
    logic [4+2*RA+RW-1:0]   romData8, romData1;
    logic [RW-1:0]          aluRes8, aluRes1;
    logic [3:0]             opCode8, opCode1;
    logic [RA-1:0]          regA8, regB8, regA1, regB1;
    logic                   rwe8, busy8, done8, pass8, rwe1, busy1, done1, pass1;
    logic [7:0]             fail8, fail1;

    logic [3:0]    romOp[NV],  modelOp[NV];
    logic [RA-1:0] romA[NV],   modelA[NV];
    logic [RA-1:0] romB[NV],   modelB[NV];
    logic [RW-1:0] romExp[NV], modelExp[NV];

    int errors = 0;
    int checks = 0;
    int t = -1;
    int cmpV, cmpPh, cmpN, cmpF;
    int bc;

    always #5 clk = ~clk;

    alu_bist_sequencer #(.REG_WIDTH(RW), .REG_ADDR_BITS(RA), .VEC_ADDR_BITS(VA),
                         .NUM_VECTORS(NV), .SETTLE_CYCLES(SC)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .vec_addr(vecAddr8), .vec_data(romData8),
        .aluResult(aluRes8), .aluOpCode(opCode8), .regAddressA(regA8), .regAddressB(regB8),
        .regWriteEnable(rwe8), .busy(busy8), .done(done8), .pass(pass8),
        .fail_count(fail8), .first_fail_index(first8));

    alu_bist_sequencer #(.REG_WIDTH(RW), .REG_ADDR_BITS(RA), .VEC_ADDR_BITS(VA),
                         .NUM_VECTORS(1), .SETTLE_CYCLES(SC)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .vec_addr(vecAddr1), .vec_data(romData1),
        .aluResult(aluRes1), .aluOpCode(opCode1), .regAddressA(regA1), .regAddressB(regB1),
        .regWriteEnable(rwe1), .busy(busy1), .done(done1), .pass(pass1),
        .fail_count(fail1), .first_fail_index(first1));

    // CPU register file holds r_i = i; the ALU answers combinationally
    function automatic logic [RW-1:0] aluRef(input logic [3:0] op, input logic [RA-1:0] a,
                                             input logic [RA-1:0] b);
        logic [RW-1:0] x;
        logic [RW-1:0] y;
        x = RW'(a);
        y = RW'(b);
        case (op)
            OP_AND:  return x & y;
            OP_OR:   return x | y;
            OP_XOR:  return x ^ y;
            OP_ADD:  return x + y;
            OP_SUB:  return x - y;
            default: return '0;
        endcase
    endfunction

    assign aluRes8 = aluRef(opCode8, regA8, regB8);
    assign aluRes1 = aluRef(opCode1, regA1, regB1);

    always @(posedge clk) romData8 <= {romOp[vecAddr8[2:0]], romA[vecAddr8[2:0]],
                                       romB[vecAddr8[2:0]], romExp[vecAddr8[2:0]]};
    always @(posedge clk) romData1 <= {OP_ADD, 3'd1, 3'd1, 16'd2};

    function automatic bit vecBad(input int k);
        return aluRef(modelOp[k], modelA[k], modelB[k]) != modelExp[k];
    endfunction

    function automatic int modelVectors();
        for (int k = 0; k < NV; k++) begin
            if (STOP_ON_FAIL && vecBad(k)) return k + 1;
        end
        return NV;
    endfunction

    function automatic int failsBefore(input int n);
        int c = 0;
        for (int k = 0; k < n; k++) begin
            if (vecBad(k) && c < 255) c++;
        end
        return c;
    endfunction

    function automatic int modelFirst();
        for (int k = 0; k < modelVectors(); k++) begin
            if (vecBad(k)) return k;
        end
        return 0;
    endfunction

    // Model: t counts cycles since the accepted start; the ROM is snapshotted per run
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            t <= -1;
        end else if (start8 && (t < 0 || t >= PER * modelVectors())) begin
            modelOp  <= romOp;
            modelA   <= romA;
            modelB   <= romB;
            modelExp <= romExp;
            t        <= 0;
        end else if (t >= 0) begin
            t <= t + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0d)", name, act, exp, t);
        end
    endtask

    // Compare process: every cycle, DUT outputs against the run model
    always @(negedge clk) begin
        if (t < 0) begin
            chk("idleOutputs", 64'({busy8, done8, pass8, rwe8, fail8, first8, vecAddr8,
                                    opCode8, regA8, regB8}), 64'(0));
        end else if (t < PER * modelVectors()) begin
            cmpV  = t / PER;
            cmpPh = t % PER;
            chk("runBusy", 64'(busy8), 64'(1));
            chk("runDone", 64'(done8), 64'(0));
            chk("runVecAddr", 64'(vecAddr8), 64'(cmpV));
            chk("runWriteStrobe", 64'(rwe8), 64'(cmpPh == 2));
            chk("runFailCount", 64'(fail8), 64'(failsBefore(cmpV)));
            if (cmpPh >= 2) begin
                chk("runOperands", 64'({opCode8, regA8, regB8}),
                    64'({modelOp[cmpV], modelA[cmpV], modelB[cmpV]}));
            end
        end else begin
            cmpN = modelVectors();
            cmpF = failsBefore(cmpN);
            chk("doneStatus", 64'({busy8, done8, pass8}), 64'({1'b0, 1'b1, cmpF == 0}));
            chk("doneFailCount", 64'(fail8), 64'(cmpF));
            chk("doneFirstFail", 64'(first8), 64'(modelFirst()));
            chk("doneVecAddr", 64'(vecAddr8), 64'(cmpN - 1));
            chk("doneWriteStrobe", 64'(rwe8), 64'(0));
        end
    end

    task automatic loadGood();
        romOp  = '{OP_AND, OP_OR, OP_XOR, OP_SUB, OP_ADD, OP_ADD, OP_SUB, OP_OR};
        romA   = '{3'd3, 3'd2, 3'd3, 3'd1, 3'd2, 3'd7, 3'd0, 3'd5};
        romB   = '{3'd3, 3'd2, 3'd3, 3'd0, 3'd3, 3'd7, 3'd1, 3'd2};
        romExp = '{16'd3, 16'd2, 16'd0, 16'd1, 16'd5, 16'd14, 16'hFFFF, 16'd7};
    endtask

    task automatic runToDone(input int extraStartAt, output int busyCycles);
        bit finished;
        busyCycles = 0;
        finished   = 1'b0;
        @(negedge clk) start8 = 1'b1;
        @(negedge clk) start8 = 1'b0;
        chk("startClearsCount", 64'(fail8), 64'(0));
        chk("startClearsDone", 64'(done8), 64'(0));
        for (int i = 0; i < 400; i++) begin
            if (done8 && !busy8) begin
                finished = 1'b1;
                break;
            end
            if (busy8) busyCycles++;
            start8 = (i == extraStartAt);
            @(negedge clk);
        end
        start8 = 1'b0;
        chk("runCompletes", 64'(finished), 64'(1));
    endtask

    initial begin
        loadGood();
        repeat (3) @(negedge clk);
        chk("resetOutputs", 64'({busy1, done1, pass1, rwe1, fail1, vecAddr1, opCode1}), 64'(0));
        reset = 1'b0;

        // Single ADD r1,r1 vector: done lands on clock 7 counting the start edge as clock 1
        @(negedge clk) start1 = 1'b1;
        @(posedge clk);
        @(negedge clk) start1 = 1'b0;
        repeat (5) @(posedge clk);
        #1 chk("oneVecNotYetDone", 64'(done1), 64'(0));
        @(posedge clk);
        #1 chk("oneVecDoneClock7", 64'({done1, pass1, busy1}), 64'({1'b1, 1'b1, 1'b0}));
        chk("oneVecFailCount", 64'(fail1), 64'(0));
        chk("oneVecAddr", 64'(vecAddr1), 64'(0));

        // All eight vectors correct
        runToDone(-1, bc);
        chk("goodBusyCycles", 64'(bc), 64'(48));
        chk("goodPass", 64'({pass8, fail8}), 64'({1'b1, 8'd0}));

        // Vector 2 expects 5 while XOR r3,r3 yields 0
        romExp[2] = 16'd5;
        runToDone(-1, bc);
        chk("vec2FailCount", 64'(fail8), 64'(1));
        chk("vec2FirstFail", 64'(first8), 64'(2));
        chk("vec2Pass", 64'(pass8), 64'(0));
        chk("vec2BusyCycles", 64'(bc), 64'(STOP_ON_FAIL ? 18 : 48));

        // Every expected value off by one bit
        loadGood();
        for (int k = 0; k < NV; k++) romExp[k] = romExp[k] ^ 16'd1;
        runToDone(-1, bc);
        chk("allBadFailCount", 64'(fail8), 64'(STOP_ON_FAIL ? 1 : 8));
        chk("allBadFirstFail", 64'(first8), 64'(0));
        chk("allBadPass", 64'(pass8), 64'(0));

        // Restart from DONE with counters set; a start pulse mid-run must be ignored
        loadGood();
        runToDone(10, bc);
        chk("ignoredStartBusyCycles", 64'(bc), 64'(48));
        chk("restartPass", 64'({pass8, fail8}), 64'({1'b1, 8'd0}));

        // Asynchronous reset during SETTLE of vector 3
        @(negedge clk) start8 = 1'b1;
        @(negedge clk) start8 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (t == 21) break;
            @(negedge clk);
        end
        chk("midRunReached", 64'({busy8, opCode8, regA8}), 64'({1'b1, OP_SUB, 3'd1}));
        #2 reset = 1'b1;
        #1 chk("asyncResetOutputs", 64'({busy8, done8, pass8, rwe8, fail8, first8, vecAddr8,
                                         opCode8, regA8, regB8}), 64'(0));
        @(negedge clk) reset = 1'b0;
        runToDone(-1, bc);
        chk("afterResetBusyCycles", 64'(bc), 64'(48));
        chk("afterResetPass", 64'(pass8), 64'(1));

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
